// File: rtl/dmem_arbiter_if.sv
// Requester-side bus for the data-memory arbiter: request fields in, grant and read-return out.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for a single-port data memory.
// Define DMEM_ARB_RR_EN for round-robin arbitration; otherwise port m0 has fixed priority.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     m0,
    dmem_arbiter_if.slave     m1,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
        $error("dmem_arbiter: READ_LAT must be in 1..4");
    end

    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               owner_q, owner_d;
    logic               gnt0_q, gnt0_d;
    logic               gnt1_q, gnt1_d;
    logic               rvalid0_q, rvalid0_d;
    logic               rvalid1_q, rvalid1_d;
    logic [DATA_W-1:0]  rdata0_q, rdata0_d;
    logic [DATA_W-1:0]  rdata1_q, rdata1_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic               mem_we_q, mem_we_d;
    logic               mem_re_q, mem_re_d;
    logic               win1;
    logic               win_we;
`ifdef DMEM_ARB_RR_EN
    // Port favoured on the next contention; always the one not granted last.
    logic               pref_q, pref_d;
`endif

    always_comb begin
`ifdef DMEM_ARB_RR_EN
        win1 = (m0.req && m1.req) ? pref_q : m1.req;
`else
        win1 = !m0.req;
`endif
        win_we = win1 ? m1.we : m0.we;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        rvalid0_d   = 1'b0;
        rvalid1_d   = 1'b0;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
`ifdef DMEM_ARB_RR_EN
        pref_d      = pref_q;
`endif

        case (state_q)
            IDLE: begin
                if (m0.req || m1.req) begin
                    owner_d     = win1;
                    gnt0_d      = !win1;
                    gnt1_d      = win1;
                    mem_addr_d  = win1 ? m1.addr  : m0.addr;
                    mem_wdata_d = win1 ? m1.wdata : m0.wdata;
`ifdef DMEM_ARB_RR_EN
                    pref_d      = !win1;
`endif
                    if (win_we) begin
                        state_d  = WRITE;
                        mem_we_d = 1'b1;
                    end else begin
                        state_d  = READ;
                        mem_re_d = 1'b1;
                        cnt_d    = CNT_W'(READ_LAT - 1);
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            READ: begin
                // Read_En stays up until the counter expires; data is taken on that final edge.
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        rdata1_d  = mem_rdata;
                        rvalid1_d = 1'b1;
                    end else begin
                        rdata0_d  = mem_rdata;
                        rvalid0_d = 1'b1;
                    end
                end else begin
                    cnt_d    = cnt_q - 1'b1;
                    mem_re_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            owner_q     <= 1'b0;
            gnt0_q      <= 1'b0;
            gnt1_q      <= 1'b0;
            rvalid0_q   <= 1'b0;
            rvalid1_q   <= 1'b0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            pref_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            gnt0_q      <= gnt0_d;
            gnt1_q      <= gnt1_d;
            rvalid0_q   <= rvalid0_d;
            rvalid1_q   <= rvalid1_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
`ifdef DMEM_ARB_RR_EN
            pref_q      <= pref_d;
`endif
        end
    end

    assign m0.gnt    = gnt0_q;
    assign m0.rvalid = rvalid0_q;
    assign m0.rdata  = rdata0_q;
    assign m1.gnt    = gnt1_q;
    assign m1.rvalid = rvalid1_q;
    assign m1.rdata  = rdata1_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, contention and reset sequences, random traffic vs. a transaction model.
module tb_dmem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RL = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic mem_we, mem_re, busy;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_if ();
    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_if ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LAT(RL)) dut (
        .clk(clk), .rst_n(rst_n), .m0(m0_if), .m1(m1_if),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory: data is only valid once Read_En has been held READ_LAT cycles.
    logic [DW-1:0] tbmem [16];
    bit mem_init_done;
    int re_cnt;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 16; i++) tbmem[i] <= 32'h1000_0000 + DW'(i);
            mem_init_done <= 1'b1;
        end else if (mem_we) begin
            tbmem[mem_addr[3:0]] <= mem_wdata;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) re_cnt <= 0;
        else        re_cnt <= mem_re ? re_cnt + 1 : 0;
    end

    assign mem_rdata = (mem_re && re_cnt >= RL - 1) ? tbmem[mem_addr[3:0]] : (32'hBAD0_0000 | mem_addr);

    int n_chk = 0;
    int n_err = 0;
    logic [DW-1:0] ref_mem [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit p, input logic req, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!p) begin
            m0_if.req = req; m0_if.we = we; m0_if.addr = a; m0_if.wdata = d;
        end else begin
            m1_if.req = req; m1_if.we = we; m1_if.addr = a; m1_if.wdata = d;
        end
    endtask

    function automatic logic gnt_of(input bit p);
        return p ? m1_if.gnt : m0_if.gnt;
    endfunction

    function automatic logic rvalid_of(input bit p);
        return p ? m1_if.rvalid : m0_if.rvalid;
    endfunction

    function automatic logic [DW-1:0] rdata_of(input bit p);
        return p ? m1_if.rdata : m0_if.rdata;
    endfunction

    // One isolated access on port p, starting and ending at posedge+1 with the arbiter idle.
    task automatic access(input bit p, input bit we, input logic [3:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp_rd);
        int n;
        int re_n;
        logic got;
        logic [DW-1:0] oth_before;
        oth_before = rdata_of(!p);
        drive(p, 1'b1, we, AW'(a), d);
        n = 0; got = 1'b0;
        while (!got && n < 8) begin
            @(posedge clk); #1;
            n++;
            got = gnt_of(p);
        end
        chk("gnt_latency", 64'(n), 64'(1));
        chk("other_gnt", 64'(gnt_of(!p)), 64'(0));
        chk("mem_addr", 64'(mem_addr), 64'(a));
        drive(p, 1'b0, 1'b0, '0, '0);
        if (we) begin
            chk("wr_enables", 64'({mem_we, mem_re}), 64'(2'b10));
            chk("mem_wdata", 64'(mem_wdata), 64'(d));
            ref_mem[a] = d;
            @(posedge clk); #1;
            chk("wr_done", 64'({mem_we, busy, gnt_of(p)}), 64'(0));
        end else begin
            chk("rd_enables", 64'({mem_we, mem_re}), 64'(2'b01));
            re_n = 1; n = 0; got = 1'b0;
            while (!got && n < 8) begin
                @(posedge clk); #1;
                n++;
                got = rvalid_of(p);
                if (!got && mem_re) re_n++;
            end
            chk("re_cycles", 64'(re_n), 64'(RL));
            chk("rvalid_latency", 64'(n), 64'(RL));
            chk("rdata", 64'(rdata_of(p)), 64'(exp_rd));
            chk("rd_done", 64'({busy, mem_re, rvalid_of(!p)}), 64'(0));
            chk("other_rdata_hold", 64'(rdata_of(!p)), 64'(oth_before));
            @(posedge clk); #1;
            chk("rvalid_pulse", 64'(rvalid_of(p)), 64'(0));
        end
    endtask

    // Both ports request continuously for a fixed window.
    task automatic contention(input bit we, input int cycles, input int exp_gnts);
        int ng;
        int nrv;
        bit exp_p;
        bit rp;
        ng = 0; nrv = 0;
        drive(1'b0, 1'b1, we, AW'(10), 32'hA0A0_0000);
        drive(1'b1, 1'b1, we, AW'(11), 32'hB1B1_0000);
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (m0_if.gnt || m1_if.gnt) begin
`ifdef DMEM_ARB_RR_EN
                exp_p = ng[0];
`else
                exp_p = 1'b0;
`endif
                chk("cont_gnt_port", 64'({m0_if.gnt, m1_if.gnt}), exp_p ? 64'(2'b01) : 64'(2'b10));
                chk("cont_mem_addr", 64'(mem_addr), exp_p ? 64'(11) : 64'(10));
                if (we) ref_mem[exp_p ? 11 : 10] = exp_p ? 32'hB1B1_0000 : 32'hA0A0_0000;
                ng++;
            end
            if (m0_if.rvalid || m1_if.rvalid) begin
                rp = m1_if.rvalid;
                chk("cont_rdata", 64'(rdata_of(rp)), 64'(ref_mem[rp ? 11 : 10]));
                nrv++;
            end
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        chk("cont_gnt_count", 64'(ng), 64'(exp_gnts));
        chk("cont_rvalid_count", 64'(nrv), we ? 64'(0) : 64'(exp_gnts));
    endtask

    typedef struct {
        bit            p;
        bit            we;
        logic [3:0]    a;
        logic [DW-1:0] d;
        logic [DW-1:0] exp_rd;
    } vec_t;

    vec_t vt [8];

    // Random-phase expectations, indexed by cycle modulo 16.
    bit            e_g0 [16], e_g1 [16], e_we [16], e_re [16], e_rv0 [16], e_rv1 [16], e_busy [16];
    logic [AW-1:0] e_addr [16];
    logic [DW-1:0] e_wd [16], e_rd0 [16], e_rd1 [16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic got;
        logic rv_seen;
        int idle_at;
        bit pref;
        int rd_gnt;
        int rv_tot;

        for (int i = 0; i < 16; i++) ref_mem[i] = 32'h1000_0000 + DW'(i);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);

        vt[0] = '{1'b0, 1'b1, 4'h2, 32'h2341_A214, 32'h0};
        vt[1] = '{1'b0, 1'b0, 4'h2, 32'h0,         32'h2341_A214};
        vt[2] = '{1'b1, 1'b1, 4'h1, 32'hDEAD_BEEF, 32'h0};
        vt[3] = '{1'b1, 1'b0, 4'h1, 32'h0,         32'hDEAD_BEEF};
        vt[4] = '{1'b1, 1'b1, 4'h7, 32'h0000_0000, 32'h0};
        vt[5] = '{1'b0, 1'b0, 4'h7, 32'h0,         32'h0000_0000};
        vt[6] = '{1'b0, 1'b1, 4'hF, 32'hFFFF_FFFF, 32'h0};
        vt[7] = '{1'b1, 1'b0, 4'hF, 32'h0,         32'hFFFF_FFFF};

        #12;
        chk("reset_ctrl", 64'({m0_if.gnt, m1_if.gnt, m0_if.rvalid, m1_if.rvalid, mem_we, mem_re, busy}), 64'(0));
        chk("reset_data", 64'({m0_if.rdata, m1_if.rdata}), 64'(0));
        chk("reset_mem_addr", 64'(mem_addr), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        contention(1'b1, 12, 6);
        contention(1'b0, 16, 4);

        for (int i = 0; i < 8; i++) access(vt[i].p, vt[i].we, vt[i].a, vt[i].d, vt[i].exp_rd);

        // Reset while a read is in flight.
        drive(1'b1, 1'b1, 1'b0, AW'(1), '0);
        n = 0; got = 1'b0;
        while (!got && n < 8) begin
            @(posedge clk); #1;
            n++;
            got = m1_if.gnt;
        end
        chk("rst_gnt_seen", 64'(got), 64'(1));
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        @(posedge clk); #1;
        chk("rst_pre_re", 64'({mem_re, busy}), 64'(2'b11));
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_drop", 64'({mem_re, mem_we, busy, m1_if.gnt, m1_if.rvalid}), 64'(0));
        rv_seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            rv_seen = rv_seen | m0_if.rvalid | m1_if.rvalid;
        end
        chk("rst_no_rvalid", 64'(rv_seen), 64'(0));
        chk("rst_rdata_cleared", 64'(m1_if.rdata), 64'(0));
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        access(1'b0, 1'b1, 4'h3, 32'h1234_5678, 32'h0);
        access(1'b0, 1'b0, 4'h3, 32'h0, 32'h1234_5678);

        // Random mixed traffic against the transaction model.
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        idle_at = 0; pref = 1'b0; rd_gnt = 0; rv_tot = 0;
        for (int k = 0; k < 1008; k++) begin
            int ix;
            bit r0, r1, w, we;
            logic [3:0] a;
            logic [DW-1:0] d;
            if (k != 0) begin
                @(posedge clk); #1;
            end
            ix = k % 16;
            chk("rnd_ctrl", 64'({m0_if.gnt, m1_if.gnt, mem_we, mem_re, m0_if.rvalid, m1_if.rvalid, busy}),
                64'({e_g0[ix], e_g1[ix], e_we[ix], e_re[ix], e_rv0[ix], e_rv1[ix], e_busy[ix]}));
            chk("rnd_excl", 64'(mem_we & mem_re), 64'(0));
            if (e_we[ix] || e_re[ix]) chk("rnd_addr", 64'(mem_addr), 64'(e_addr[ix]));
            if (e_we[ix]) chk("rnd_wdata", 64'(mem_wdata), 64'(e_wd[ix]));
            if (e_rv0[ix]) chk("rnd_rdata0", 64'(m0_if.rdata), 64'(e_rd0[ix]));
            if (e_rv1[ix]) chk("rnd_rdata1", 64'(m1_if.rdata), 64'(e_rd1[ix]));
            if ((m0_if.gnt || m1_if.gnt) && mem_re) rd_gnt++;
            if (m0_if.rvalid) rv_tot++;
            if (m1_if.rvalid) rv_tot++;
            e_g0[ix] = 0; e_g1[ix] = 0; e_we[ix] = 0; e_re[ix] = 0;
            e_rv0[ix] = 0; e_rv1[ix] = 0; e_busy[ix] = 0;

            for (int p = 0; p < 2; p++) begin
                logic cur;
                cur = p[0] ? m1_if.req : m0_if.req;
                if (k >= 1000) begin
                    drive(p[0], 1'b0, 1'b0, '0, '0);
                end else if (!cur || gnt_of(p[0])) begin
                    if ($urandom_range(0, 2) != 0)
                        drive(p[0], 1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
                    else
                        drive(p[0], 1'b0, 1'b0, '0, '0);
                end
            end

            r0 = m0_if.req; r1 = m1_if.req;
            if (k >= idle_at && (r0 || r1)) begin
`ifdef DMEM_ARB_RR_EN
                w = (r0 && r1) ? pref : r1;
                pref = !w;
`else
                w = !r0;
`endif
                we = w ? m1_if.we : m0_if.we;
                a  = w ? m1_if.addr[3:0] : m0_if.addr[3:0];
                d  = w ? m1_if.wdata : m0_if.wdata;
                if (w) e_g1[(k + 1) % 16] = 1; else e_g0[(k + 1) % 16] = 1;
                if (we) begin
                    e_we[(k + 1) % 16]   = 1;
                    e_busy[(k + 1) % 16] = 1;
                    e_addr[(k + 1) % 16] = AW'(a);
                    e_wd[(k + 1) % 16]   = d;
                    ref_mem[a] = d;
                    idle_at = k + 2;
                end else begin
                    for (int t = 1; t <= RL; t++) begin
                        e_re[(k + t) % 16]   = 1;
                        e_busy[(k + t) % 16] = 1;
                        e_addr[(k + t) % 16] = AW'(a);
                    end
                    if (w) begin
                        e_rv1[(k + RL + 1) % 16] = 1;
                        e_rd1[(k + RL + 1) % 16] = ref_mem[a];
                    end else begin
                        e_rv0[(k + RL + 1) % 16] = 1;
                        e_rd0[(k + RL + 1) % 16] = ref_mem[a];
                    end
                    idle_at = k + RL + 1;
                end
            end
        end
        chk("rnd_rvalid_per_read_gnt", 64'(rv_tot), 64'(rd_gnt));

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
